uart_rx_param: RTL and testbench

Parametrised UART receiver: oversampled start detection, majority-vote bit sampling, configurable data width, optional parity and 1 or 2 stop bits, with registered error flags. It replaces the fixed 8-bit receiver in the UART subsystem and feeds a parallel word plus a one-cycle valid strobe to the downstream register/FIFO stage. Line configuration is sampled per frame, so software can reconfigure between frames without a reset.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_rx_sampler.sv | 68 ++++++
 rtl/uart_rx_param.sv | 132 +++++++++++++
 tb/tb_uart_rx_param.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the parametrised UART receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        DONE
    } rx_state_t;

    // Majority samples are taken at P/2-SAMPLE_OFS, P/2 and P/2+SAMPLE_OFS.
    localparam int SAMPLE_OFS     = 1;
    localparam int DATA_WIDTH_MIN = 5;
    localparam int DATA_WIDTH_MAX = 9;

endpackage

// File: rtl/uart_rx_sampler.sv
// Line synchroniser, per-bit edge counter, frame bit counter and
// three-sample majority vote for the UART receiver.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int PRESCALE_W  = 6,
    parameter int SYNC_STAGES = 2,
    parameter int BIT_CNT_W   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  active,
    output logic                  rxs,
    output logic                  bit_done,
    output logic                  bit_val,
    output logic                  bit_wrap,
    output logic [BIT_CNT_W-1:0]  bit_cnt
);

    localparam logic [PRESCALE_W-1:0] OFS     = PRESCALE_W'(SAMPLE_OFS);
    localparam logic [PRESCALE_W-1:0] ONE     = PRESCALE_W'(1);
    localparam logic [BIT_CNT_W-1:0]  BIT_ONE = BIT_CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [PRESCALE_W-1:0]  edge_cnt;
    logic [PRESCALE_W-1:0]  half;
    logic                   samp_lo;
    logic                   samp_mid;

    // NOTE: synchroniser flops reset to 1 (idle line) so reset release never looks like a start edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync_q <= '1;
        else      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
    end

    assign rxs  = sync_q[SYNC_STAGES-1];
    assign half = {1'b0, prescale[PRESCALE_W-1:1]};

    // Counters sit at 0 while idle, so neither strobe can fire outside a frame.
    assign bit_wrap = (edge_cnt == prescale - ONE);
    assign bit_done = (edge_cnt == half + OFS);
    assign bit_val  = (samp_lo & samp_mid) | (samp_lo & rxs) | (samp_mid & rxs);

    // NOTE: clocked state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
            samp_lo  <= 1'b0;
            samp_mid <= 1'b0;
        end else if (!active) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            if (bit_wrap) begin
                edge_cnt <= '0;
                bit_cnt  <= bit_cnt + BIT_ONE;
            end else begin
                edge_cnt <= edge_cnt + ONE;
            end
            if (edge_cnt == half - OFS) samp_lo  <= rxs;
            if (edge_cnt == half)       samp_mid <= rxs;
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: frame FSM, shift register, parity/stop checks
// and registered output strobes on top of the oversampling sampler.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int PRESCALE_W  = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stop_err,
    output logic                  busy
);

    localparam int BIT_CNT_W = $clog2(DATA_WIDTH_MAX + 5);
    localparam logic [BIT_CNT_W-1:0] LAST_DATA_IDX = BIT_CNT_W'(DATA_WIDTH);

    if (DATA_WIDTH < DATA_WIDTH_MIN || DATA_WIDTH > DATA_WIDTH_MAX) begin : g_bad_width
        $error("uart_rx_param: DATA_WIDTH outside supported range");
    end

    rx_state_t             state, next_state;
    logic                  rxs, bit_done, bit_val, bit_wrap, active;
    logic [BIT_CNT_W-1:0]  bit_cnt, last_stop_idx;
    logic [PRESCALE_W-1:0] fr_prescale;
    logic                  fr_par_en, fr_par_typ, fr_stop2;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  par_flag_q, stop_flag_q;
    logic                  frame_end, stop_bad, valid_d, par_err_d, stop_err_d;

    // Counting starts in the detection cycle (edge 0) and stops on leaving the frame.
    assign active = (next_state != IDLE) && (next_state != DONE);
    assign last_stop_idx = LAST_DATA_IDX + BIT_CNT_W'(fr_par_en) + BIT_CNT_W'(fr_stop2)
                         + BIT_CNT_W'(1);

    uart_rx_sampler #(
        .PRESCALE_W  (PRESCALE_W),
        .SYNC_STAGES (SYNC_STAGES),
        .BIT_CNT_W   (BIT_CNT_W)
    ) u_sampler (
        .clk      (clk),
        .rst      (rst),
        .rx       (RX_IN),
        .prescale (fr_prescale),
        .active   (active),
        .rxs      (rxs),
        .bit_done (bit_done),
        .bit_val  (bit_val),
        .bit_wrap (bit_wrap),
        .bit_cnt  (bit_cnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    // NOTE: next_state gets its default first, so no branch can infer a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:   if (!rxs) next_state = START;
            START:  if (bit_done && bit_val) next_state = IDLE;
                    else if (bit_wrap)       next_state = DATA;
            DATA:   if (bit_wrap && bit_cnt == LAST_DATA_IDX)
                        next_state = fr_par_en ? PARITY : STOP;
            PARITY: if (bit_wrap) next_state = STOP;
            STOP:   if (bit_done && bit_cnt == last_stop_idx) next_state = DONE;
            DONE:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Strobes are computed on entry to DONE and registered, so they coincide with DONE.
    always_comb begin
        busy       = (state != IDLE);
        frame_end  = (state == STOP) && (next_state == DONE);
        stop_bad   = stop_flag_q || !bit_val;
        valid_d    = frame_end && !par_flag_q && !stop_bad;
        par_err_d  = frame_end && par_flag_q;
        stop_err_d = frame_end && stop_bad;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            P_DATA      <= '0;
            data_valid  <= 1'b0;
            par_err     <= 1'b0;
            stop_err    <= 1'b0;
            shift_q     <= '0;
            par_flag_q  <= 1'b0;
            stop_flag_q <= 1'b0;
            fr_prescale <= '0;
            fr_par_en   <= 1'b0;
            fr_par_typ  <= 1'b0;
            fr_stop2    <= 1'b0;
        end else begin
            data_valid <= valid_d;
            par_err    <= par_err_d;
            stop_err   <= stop_err_d;
            if (valid_d) P_DATA <= shift_q;

            if (state == IDLE) begin
                par_flag_q  <= 1'b0;
                stop_flag_q <= 1'b0;
                if (!rxs) begin
                    fr_prescale <= Prescale;
                    fr_par_en   <= PAR_EN;
                    fr_par_typ  <= PAR_TYP;
                    fr_stop2    <= STOP2;
                end
            end

            if (state == DATA && bit_done)
                shift_q <= {bit_val, shift_q[DATA_WIDTH-1:1]};
            if (state == PARITY && bit_done)
                par_flag_q <= bit_val ^ (^shift_q) ^ fr_par_typ;
            if (state == STOP && bit_done && !bit_val)
                stop_flag_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed self-checking bench for uart_rx_param (8-bit and 5-bit builds).
module tb_uart_rx_param;

    localparam int SYNC = 2;
    localparam int PW   = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx;
    logic          rx5;
    logic [PW-1:0] prescale;
    logic          par_en;
    logic          par_typ;
    logic          stop2;
    logic [7:0]    p_data;
    logic          dv, pe, se, busy;
    logic [4:0]    p_data5;
    logic          dv5, pe5, se5, busy5;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         t_fall = 0;
    int         dv_cyc = 0;
    int         dv_cnt, pe_cnt, se_cnt, dv5_cnt, err5_cnt;
    logic [7:0] words[$];
    logic [4:0] last5;

    uart_rx_param #(.DATA_WIDTH(8), .PRESCALE_W(PW), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst(rst), .RX_IN(rx), .Prescale(prescale), .PAR_EN(par_en),
        .PAR_TYP(par_typ), .STOP2(stop2), .P_DATA(p_data), .data_valid(dv),
        .par_err(pe), .stop_err(se), .busy(busy)
    );

    uart_rx_param #(.DATA_WIDTH(5), .PRESCALE_W(PW), .SYNC_STAGES(SYNC)) dut5 (
        .clk(clk), .rst(rst), .RX_IN(rx5), .Prescale(prescale), .PAR_EN(par_en),
        .PAR_TYP(par_typ), .STOP2(stop2), .P_DATA(p_data5), .data_valid(dv5),
        .par_err(pe5), .stop_err(se5), .busy(busy5)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #300000;
        $fatal(1, "FAIL watchdog: simulation did not finish");
    end

    always @(negedge clk) begin
        if (dv) begin
            dv_cnt++;
            dv_cyc = cyc;
            words.push_back(p_data);
        end
        if (pe) pe_cnt++;
        if (se) se_cnt++;
        if (dv5) begin
            dv5_cnt++;
            last5 = p_data5;
        end
        if (pe5 || se5) err5_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        dv_cnt   = 0;
        pe_cnt   = 0;
        se_cnt   = 0;
        dv5_cnt  = 0;
        err5_cnt = 0;
        last5    = 5'h0;
        words.delete();
    endtask

    task automatic seg(input bit to5, input logic v, input int n);
        if (to5) rx5 = v;
        else     rx  = v;
        repeat (n) @(negedge clk);
    endtask

    // LSB-first frame; glitch_bit inverts that data bit for one cycle at mid-bit.
    task automatic send_frame(input logic [8:0] data, input int dw, input int p,
                              input bit has_par, input bit par_bit, input int n_stop,
                              input bit last_stop, input int last_len,
                              input int glitch_bit, input bit to5);
        t_fall = cyc;
        seg(to5, 1'b0, p);
        for (int i = 0; i < dw; i++) begin
            if (i == glitch_bit) begin
                seg(to5, data[i], p / 2);
                seg(to5, ~data[i], 1);
                seg(to5, data[i], p - p / 2 - 1);
            end else begin
                seg(to5, data[i], p);
            end
        end
        if (has_par) seg(to5, par_bit, p);
        for (int s = 0; s < n_stop; s++)
            seg(to5, (s == n_stop - 1) ? last_stop : 1'b1, (s == n_stop - 1) ? last_len : p);
    endtask

    initial begin
        rst      = 1'b0;
        rx       = 1'b1;
        rx5      = 1'b1;
        prescale = 6'd8;
        par_en   = 1'b0;
        par_typ  = 1'b0;
        stop2    = 1'b0;
        clear_counts();
        repeat (3) @(negedge clk);

        check("rst_p_data",  32'(p_data), 32'h0);
        check("rst_valid",   32'(dv), 32'h0);
        check("rst_par_err", 32'(pe), 32'h0);
        check("rst_stop_err", 32'(se), 32'h0);
        check("rst_busy",    32'(busy), 32'h0);
        check("rst_p_data5", 32'(p_data5), 32'h0);

        rst = 1'b1;
        repeat (4) @(negedge clk);

        // Plain 8N1 frame at Prescale 8, with latency from start edge to data_valid.
        send_frame(9'h0A5, 8, 8, 1'b0, 1'b0, 1, 1'b1, 8, -1, 1'b0);
        seg(1'b0, 1'b1, 6);
        check("a5_data",     32'(p_data), 32'hA5);
        check("a5_valids",   32'(dv_cnt), 32'd1);
        check("a5_par_errs", 32'(pe_cnt), 32'd0);
        check("a5_stop_errs", 32'(se_cnt), 32'd0);
        check("a5_latency",  32'(dv_cyc - t_fall - 1), 32'(8 * 9 + 4 + SYNC + 1));
        check("a5_busy_idle", 32'(busy), 32'h0);

        // Even parity, correct then wrong parity bit.
        par_en  = 1'b1;
        par_typ = 1'b0;
        clear_counts();
        send_frame(9'h03C, 8, 8, 1'b1, 1'b0, 1, 1'b1, 8, -1, 1'b0);
        seg(1'b0, 1'b1, 6);
        check("par_ok_data",   32'(p_data), 32'h3C);
        check("par_ok_valids", 32'(dv_cnt), 32'd1);
        check("par_ok_errs",   32'(pe_cnt), 32'd0);

        clear_counts();
        send_frame(9'h03C, 8, 8, 1'b1, 1'b1, 1, 1'b1, 8, -1, 1'b0);
        seg(1'b0, 1'b1, 6);
        check("par_bad_errs",     32'(pe_cnt), 32'd1);
        check("par_bad_valids",   32'(dv_cnt), 32'd0);
        check("par_bad_data",     32'(p_data), 32'h3C);
        check("par_bad_stop_errs", 32'(se_cnt), 32'd0);

        // Two stop bits with the second one low.
        par_en = 1'b0;
        stop2  = 1'b1;
        clear_counts();
        send_frame(9'h081, 8, 8, 1'b0, 1'b0, 2, 1'b0, 8, -1, 1'b0);
        seg(1'b0, 1'b1, 24);
        check("stop_bad_errs",    32'(se_cnt), 32'd1);
        check("stop_bad_valids",  32'(dv_cnt), 32'd0);
        check("stop_bad_data",    32'(p_data), 32'h3C);
        check("stop_bad_par_errs", 32'(pe_cnt), 32'd0);

        // Two-cycle start glitch at Prescale 16, then a good frame.
        stop2    = 1'b0;
        prescale = 6'd16;
        clear_counts();
        seg(1'b0, 1'b0, 2);
        seg(1'b0, 1'b1, 3);
        check("glitch_busy_high", 32'(busy), 32'h1);
        seg(1'b0, 1'b1, 9);
        check("glitch_busy_low", 32'(busy), 32'h0);
        seg(1'b0, 1'b1, 160);
        check("glitch_valids",    32'(dv_cnt), 32'd0);
        check("glitch_par_errs",  32'(pe_cnt), 32'd0);
        check("glitch_stop_errs", 32'(se_cnt), 32'd0);
        send_frame(9'h055, 8, 16, 1'b0, 1'b0, 1, 1'b1, 16, -1, 1'b0);
        seg(1'b0, 1'b1, 8);
        check("after_glitch_data",   32'(p_data), 32'h55);
        check("after_glitch_valids", 32'(dv_cnt), 32'd1);

        // Back-to-back: first stop cut to just past its decision point,
        // second frame carries a one-cycle glitch in data bit 3.
        prescale = 6'd8;
        clear_counts();
        send_frame(9'h012, 8, 8, 1'b0, 1'b0, 1, 1'b1, 6, -1, 1'b0);
        send_frame(9'h034, 8, 8, 1'b0, 1'b0, 1, 1'b1, 8, 3, 1'b0);
        seg(1'b0, 1'b1, 6);
        check("b2b_valids", 32'(dv_cnt), 32'd2);
        check("b2b_word0", 32'((words.size() > 0) ? words[0] : 8'hEE), 32'h12);
        check("b2b_word1", 32'((words.size() > 1) ? words[1] : 8'hEE), 32'h34);
        check("b2b_par_errs",  32'(pe_cnt), 32'd0);
        check("b2b_stop_errs", 32'(se_cnt), 32'd0);

        // Reset in the middle of data bit 4 of frame 0x5A.
        clear_counts();
        seg(1'b0, 1'b0, 8);
        seg(1'b0, 1'b0, 8);
        seg(1'b0, 1'b1, 8);
        seg(1'b0, 1'b0, 8);
        seg(1'b0, 1'b1, 8);
        seg(1'b0, 1'b1, 4);
        check("pre_rst_busy", 32'(busy), 32'h1);
        rst = 1'b0;
        #1;
        check("mid_rst_p_data",   32'(p_data), 32'h0);
        check("mid_rst_busy",     32'(busy), 32'h0);
        check("mid_rst_valid",    32'(dv), 32'h0);
        check("mid_rst_stop_err", 32'(se), 32'h0);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        clear_counts();
        seg(1'b0, 1'b1, 120);
        check("post_rst_valids",    32'(dv_cnt), 32'd0);
        check("post_rst_par_errs",  32'(pe_cnt), 32'd0);
        check("post_rst_stop_errs", 32'(se_cnt), 32'd0);
        check("post_rst_busy",      32'(busy), 32'h0);

        // Five-bit build.
        clear_counts();
        send_frame(9'h01B, 5, 8, 1'b0, 1'b0, 1, 1'b1, 8, -1, 1'b1);
        seg(1'b1, 1'b1, 6);
        check("w5_data",      32'(p_data5), 32'h1B);
        check("w5_strobe",    32'(last5), 32'h1B);
        check("w5_valids",    32'(dv5_cnt), 32'd1);
        check("w5_errs",      32'(err5_cnt), 32'd0);
        check("w5_other_dut", 32'(dv_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
